// File: rtl/serdes_pkg.sv
// Shared definitions for the shift-based serial path: receiver FSM states
// and the bit-order encoding used by both the serializer and deserializer.
package serdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage : serdes_pkg

// File: rtl/deser_out_reg.sv
// One-entry holding register between the deserializer and its consumer.
// Valid/ready: a word transfers on any rising edge where o_valid & i_ready.
module deser_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             w_accept;
    logic             w_drain;

    // A new word may enter when the slot is empty or is being emptied this cycle.
    assign w_accept = i_load & (~r_valid | i_ready);
    assign w_drain  = r_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load & r_valid & ~i_ready;
            if (w_accept) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule : deser_out_reg

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB- or LSB-first
// and hands them to a one-entry valid/ready output register.
module serial_deserializer
    import serdes_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             msb_first,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_next;
    logic [CW-1:0]    r_count;
    logic             r_dir;
    logic             w_dir_eff;
    logic             w_last_bit;
    logic             w_complete;

    // The first bit of a word uses the live msb_first; later bits use the latched copy.
    assign w_dir_eff  = (r_state == IDLE) ? msb_first : r_dir;
    assign w_sr_next  = (w_dir_eff == DIR_MSB_FIRST) ? {r_sr[WIDTH-2:0], sin}
                                                     : {sin, r_sr[WIDTH-1:1]};
    assign w_last_bit = (r_count == CW'(WIDTH - 1));
    assign w_complete = (r_state == SHIFT) & sin_valid & w_last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (sin_valid) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_complete) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr    <= '0;
            r_count <= '0;
            r_dir   <= DIR_LSB_FIRST;
        end else if (sin_valid) begin
            r_sr <= w_sr_next;
            if (r_state == IDLE) begin
                r_dir   <= msb_first;
                r_count <= CW'(1);
            end else if (w_last_bit) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    deser_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_complete),
        .i_data    (w_sr_next),
        .i_ready   (out_ready),
        .o_data    (out_data),
        .o_valid   (out_valid),
        .o_overrun (overrun)
    );

endmodule : serial_deserializer

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: directed scenarios plus random traffic,
// checked against a bit-list reference model through an expected-word queue.
module tb_serial_deserializer;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         sin;
    logic         sin_valid;
    logic         msb_first;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         overrun;

    serial_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sin_valid (sin_valid),
        .msb_first (msb_first),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: bits of the word in flight, and the holder occupancy.
    logic         m_bits[$];
    logic         m_dir;
    logic         m_valid;
    logic         m_busy;
    logic         m_ovr;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] assemble();
        int unsigned val = 0;
        for (int i = 0; i < W; i++) begin
            if (m_bits[i]) val += m_dir ? (1 << (W - 1 - i)) : (1 << i);
        end
        return W'(val);
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_dir   = 1'b0;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_ovr   = 1'b0;
        exp_q.delete();
    endtask

    // Called at each rising edge with the inputs that edge samples.
    task automatic model_edge();
        logic done = 1'b0;
        logic [W-1:0] word = '0;
        m_ovr = 1'b0;
        if (sin_valid) begin
            if (m_bits.size() == 0) m_dir = msb_first;
            m_bits.push_back(sin);
            if (m_bits.size() == W) begin
                word = assemble();
                done = 1'b1;
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || out_ready) begin
                exp_q.push_back(word);
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        m_busy = (m_bits.size() != 0);
    endtask

    task automatic tick(input logic v, input logic s, input logic m, input logic r);
        sin_valid = v;
        sin       = s;
        msb_first = m;
        out_ready = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Idle cycle with out_ready low that also checks the holder directly.
    task automatic peek(input string name, input logic exp_v, input logic [W-1:0] exp_d);
        sin_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'(exp_v));
        check({name, "_data"}, 32'(out_data), 32'(exp_d));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic msb);
        for (int i = 0; i < W; i++) begin
            tick(1'b1, msb ? w[W-1-i] : w[i], msb, 1'b0);
        end
    endtask

    // Monitor: compares DUT outputs against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_valid", 32'(out_valid), 32'd0);
                check("rst_data", 32'(out_data), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_overrun", 32'(overrun), 32'd0);
            end else begin
                check("busy", 32'(busy), 32'(m_busy));
                check("overrun", 32'(overrun), 32'(m_ovr));
                check("out_valid", 32'(out_valid), 32'(m_valid));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else if (out_ready) begin
                        check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
                    end else begin
                        check("hold_data", 32'(out_data), 32'(exp_q[0]));
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        msb_first = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // MSB-first 1,0,1,1
        send_word(4'b1011, 1'b1);
        peek("tp1", 1'b1, 4'b1011);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // LSB-first 1,0,1,1 with a gap after bit 2
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        peek("tp2", 1'b1, 4'b1101);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun: A then 5 with consumer stalled
        send_word(4'hA, 1'b1);
        send_word(4'h5, 1'b1);
        peek("tp3_hold", 1'b1, 4'hA);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        peek("tp3_drained", 1'b0, 4'hA);

        // Completion coinciding with out_ready
        send_word(4'h3, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        peek("tp4", 1'b1, 4'hC);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // msb_first toggled mid-word is ignored
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        peek("tp5", 1'b1, 4'b1100);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-word, then a fresh word
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_word(4'b0110, 1'b1);
        peek("tp6", 1'b1, 4'b0110);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            tick(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom),
                 1'($urandom), ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
        end

        repeat (W + 2) tick(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_deserializer

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
Serial-to-parallel receiver that assembles a WIDTH-bit word from a bit stream, one bit per accepted clock, in MSB-first or LSB-first order. It is the receiving end of the team's shift-based serial path: a shifting serializer sends the bits, and this block rebuilds the word. The completed word goes to a one-entry output holding register with a valid/ready handshake to the downstream consumer.

Parameters:
WIDTH, 4, word width in bits; legal range >= 2.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous, active-low reset
sin  input  1  serial data bit
sin_valid  input  1  sin carries a bit this cycle; always accepted, no backpressure
msb_first  input  1  1 = first bit of a word is the MSB; 0 = first bit is the LSB
out_data  output  WIDTH  assembled word, stable while out_valid=1
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer takes the word when out_valid & out_ready
busy  output  1  a word is partially received (state SHIFT)
overrun  output  1  one-cycle pulse: a word completed while the holder was full, and the word was dropped

Behaviour:
- Reset: asserting rst_n low immediately clears the state to IDLE, the shift register and bit counter to 0, out_data to 0, and out_valid, busy and overrun to 0. A partial word in progress at reset is discarded.
- State IDLE: on sin_valid=1:
  - Latch msb_first into an internal dir_q for the whole word.
  - Shift in the first bit and set count=1.
  - Go to SHIFT.
- State SHIFT: on each sin_valid=1, shift in one bit and increment count.
  - sin_valid=0 cycles are gaps: no state change and no timeout.
  - msb_first changes during SHIFT are ignored.
- Shift rule:
  - dir_q=1: sr <= {sr[WIDTH-2:0], sin}, so the first bit ends at the MSB.
  - dir_q=0: sr <= {sin, sr[WIDTH-1:1]}, so the first bit ends at the LSB.
- Completion: the edge that accepts bit number WIDTH (count==WIDTH-1 beforehand) completes the word.
  - Return to IDLE with count=0.
  - If the holder is free, or is freed this same cycle by out_ready, load the completed word (sr including the final bit) into out_data and set out_valid=1.
  - So out_valid is high in the cycle after the last bit is sampled: latency is 1 cycle from the last bit.
- Back-to-back words: the next word may start in the cycle immediately after completion. Sustained throughput is one word per WIDTH accepted bits.
- Handshake:
  - out_valid & out_ready in a cycle with no completion clears out_valid on the next edge.
  - out_data is unchanged while out_valid=1 and out_ready=0.
  - Completion and out_ready in the same cycle: new word loaded, out_valid stays 1, no overrun.
- Overrun: completion while out_valid=1 and out_ready=0.
  - The new word is dropped; out_data keeps the old word.
  - overrun=1 for exactly one cycle, then the receiver returns to IDLE.
- busy = (state==SHIFT), registered.
- Width rules: count is $clog2(WIDTH) bits and never exceeds WIDTH-1.

Decomposition:
- Shared package serdes_pkg:
  - State enum {IDLE, SHIFT}.
  - Direction constants DIR_LSB_FIRST=0 and DIR_MSB_FIRST=1, shared with the serializer side.
- One natural sub-module, deser_out_reg: the one-entry holding register with the valid/ready logic and overrun detection. The shift register, counter and FSM stay in the top module.

Test Plan:
- WIDTH=4, msb_first=1, bits 1,0,1,1 on consecutive cycles -> out_data=4'b1011 and out_valid=1 the cycle after the 4th bit; busy=1 during bits 2-4.
- msb_first=0, bits 1,0,1,1 with a 3-cycle sin_valid=0 gap after bit 2 -> out_data=4'b1101; busy holds 1 through the gap.
- out_ready=0, send words 4'hA then 4'h5 (MSB-first) -> out_data stays 4'hA and overrun pulses 1 cycle at the completion of 4'h5; after out_ready=1, out_valid drops and out_data stays 4'hA.
- out_ready=1 exactly on the completion edge of a second word -> out_data updates to the second word, out_valid stays 1, overrun=0.
- msb_first toggled after bit 1 of 1,1,0,0 (latched 1) -> out_data=4'b1100, toggle ignored.
- rst_n pulsed low after 2 bits, then 4 fresh bits 0,1,1,0 MSB-first -> outputs 0 during reset, then out_data=4'b0110 with no residue from the aborted word.
